// File: rtl/approx_adder_err_monitor_if.sv
// Bus between the approximate-adder error monitor and its environment.
// The slave side is the monitor. The master side drives start/et and returns the adder result.
interface approx_adder_err_monitor_if;
  logic       start;
  logic [2:0] et;
  logic [3:0] dut_in;
  logic [2:0] dut_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] max_err;
  logic [4:0] err_cnt;
  logic       fail_valid;
  logic [3:0] fail_vec;

  modport master (
    output start, et, dut_out,
    input  dut_in, busy, done, pass, max_err, err_cnt, fail_valid, fail_vec
  );

  modport slave (
    input  start, et, dut_out,
    output dut_in, busy, done, pass, max_err, err_cnt, fail_valid, fail_vec
  );
endinterface

// File: rtl/approx_adder_err_monitor.sv
// Exhaustive 16-vector sweep of a 2-bit approximate adder.
// Tracks the maximum absolute error, the count of erroneous vectors and the first vector over threshold.
module approx_adder_err_monitor (
  input  logic                         clk,
  input  logic                         rst_n,
  approx_adder_err_monitor_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic [3:0]  vec_r;
  logic [2:0]  et_r;
  logic [2:0]  max_err_r;
  logic [4:0]  err_cnt_r;
  logic        fail_valid_r;
  logic [3:0]  fail_vec_r;
  logic [2:0]  err_s;
  logic        accept_s;
  logic        busy_s;
  logic        done_s;

  // |y - (a + b)| without wrap; a = v[1:0], b = v[3:2]
  function automatic logic [2:0] abs_err(input logic [3:0] v, input logic [2:0] y);
    logic [2:0] s;
    s = {1'b0, v[1:0]} + {1'b0, v[3:2]};
    if (y >= s) begin
      abs_err = y - s;
    end else begin
      abs_err = s - y;
    end
  endfunction

  assign err_s    = abs_err(vec_r, bus.dut_out);
  assign accept_s = (state_r == IDLE) && bus.start;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_next_s = SWEEP;
        end else begin
          state_next_s = IDLE;
        end
      end
      SWEEP: begin
        if (vec_r == 4'd15) begin
          state_next_s = DONE;
        end else begin
          state_next_s = SWEEP;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State-decoded status outputs
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_r)
      IDLE:    begin busy_s = 1'b0; done_s = 1'b0; end
      SWEEP:   begin busy_s = 1'b1; done_s = 1'b0; end
      DONE:    begin busy_s = 1'b0; done_s = 1'b1; end
      default: begin busy_s = 1'b0; done_s = 1'b0; end
    endcase
  end

  // Vector counter, threshold latch and result accumulators
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_r        <= 4'd0;
      et_r         <= 3'd0;
      max_err_r    <= 3'd0;
      err_cnt_r    <= 5'd0;
      fail_valid_r <= 1'b0;
      fail_vec_r   <= 4'd0;
    end else if (accept_s) begin
      vec_r        <= 4'd0;
      et_r         <= bus.et;
      max_err_r    <= 3'd0;
      err_cnt_r    <= 5'd0;
      fail_valid_r <= 1'b0;
      fail_vec_r   <= 4'd0;
    end else if (state_r == SWEEP) begin
      // Counter wraps 15 -> 0, so it is already 0 in DONE and the following IDLE
      vec_r <= vec_r + 4'd1;
      if (err_s > max_err_r) begin
        max_err_r <= err_s;
      end
      if (err_s != 3'd0) begin
        err_cnt_r <= err_cnt_r + 5'd1;
      end
      if ((err_s > et_r) && !fail_valid_r) begin
        fail_valid_r <= 1'b1;
        fail_vec_r   <= vec_r;
      end
    end else begin
      vec_r <= 4'd0;
    end
  end

  assign bus.dut_in     = vec_r;
  assign bus.busy       = busy_s;
  assign bus.done       = done_s;
  assign bus.max_err    = max_err_r;
  assign bus.err_cnt    = err_cnt_r;
  assign bus.fail_valid = fail_valid_r;
  assign bus.fail_vec   = fail_vec_r;
  assign bus.pass       = (max_err_r <= et_r);

endmodule

// File: tb/tb_approx_adder_err_monitor.sv
// Directed bench for approx_adder_err_monitor: one task per scenario, with hand-computed expectations.
module tb_approx_adder_err_monitor;

  logic clk = 1'b0;
  logic rst_n;
  int   mode;      // 0 exact adder, 1 output tied to 0, 2 exact with out0 inverted
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  approx_adder_err_monitor_if bus ();

  approx_adder_err_monitor dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [2:0] exact_sum;
  assign exact_sum = {1'b0, bus.dut_in[1:0]} + {1'b0, bus.dut_in[3:2]};

  always_comb begin
    case (mode)
      0:       bus.dut_out = exact_sum;
      1:       bus.dut_out = 3'd0;
      2:       bus.dut_out = exact_sum ^ 3'b001;
      default: bus.dut_out = exact_sum;
    endcase
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired got timeout exp finish");
    $fatal(1, "watchdog");
  end

  // Accept one start with threshold et0, switch et to et1 in cycle 4, and observe cycles 1..20 after E0
  task automatic run_sweep(input logic [2:0] et0, input logic [2:0] et1,
                           output int seq_bad, output int done_at);
    seq_bad = 0;
    done_at = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.et    = et0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (k == 4) bus.et = et1;
      if (k <= 16 && (bus.dut_in !== 4'(k - 1) || bus.busy !== 1'b1 || bus.done !== 1'b0)) seq_bad++;
      if (k >= 17 && bus.busy !== 1'b0) seq_bad++;
      if (bus.done === 1'b1) begin
        if (done_at == 0) done_at = k;
        else seq_bad++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.et    = 3'd0;
    mode      = 0;
    #12;
    tests++;
    if ({bus.dut_in, bus.busy, bus.done, bus.max_err, bus.err_cnt, bus.fail_valid, bus.fail_vec, bus.pass}
        !== {4'd0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0, 4'd0, 1'b1}) begin
      fails++;
      $display("FAIL reset_state got dut_in=%0d busy=%0d done=%0d me=%0d ec=%0d fv=%0d fvec=%0d pass=%0d exp 0 0 0 0 0 0 0 1",
               bus.dut_in, bus.busy, bus.done, bus.max_err, bus.err_cnt, bus.fail_valid, bus.fail_vec, bus.pass);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.busy !== 1'b0 || bus.dut_in !== 4'd0) begin
      fails++;
      $display("FAIL idle_after_reset got busy=%0d dut_in=%0d exp busy=0 dut_in=0", bus.busy, bus.dut_in);
    end
  endtask

  task automatic test_exact();
    int seq_bad, done_at;
    mode = 0;
    run_sweep(3'd0, 3'd0, seq_bad, done_at);
    tests++;
    if (seq_bad !== 0) begin fails++; $display("FAIL exact_sequence got %0d bad cycles exp 0", seq_bad); end
    tests++;
    if (done_at !== 17) begin fails++; $display("FAIL exact_done_cycle got %0d exp 17", done_at); end
    tests++;
    if ({bus.max_err, bus.err_cnt, bus.fail_valid, bus.pass} !== {3'd0, 5'd0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL exact_results got me=%0d ec=%0d fv=%0d pass=%0d exp me=0 ec=0 fv=0 pass=1",
               bus.max_err, bus.err_cnt, bus.fail_valid, bus.pass);
    end
  endtask

  task automatic test_zero();
    int seq_bad, done_at;
    mode = 1;
    run_sweep(3'd0, 3'd0, seq_bad, done_at);
    tests++;
    if (seq_bad !== 0 || done_at !== 17) begin
      fails++;
      $display("FAIL zero_sequence got bad=%0d done_at=%0d exp bad=0 done_at=17", seq_bad, done_at);
    end
    tests++;
    if ({bus.max_err, bus.err_cnt, bus.fail_valid, bus.fail_vec, bus.pass} !== {3'd6, 5'd15, 1'b1, 4'd1, 1'b0}) begin
      fails++;
      $display("FAIL zero_results got me=%0d ec=%0d fv=%0d fvec=%0d pass=%0d exp me=6 ec=15 fv=1 fvec=1 pass=0",
               bus.max_err, bus.err_cnt, bus.fail_valid, bus.fail_vec, bus.pass);
    end
  endtask

  task automatic test_inverted_lsb();
    int seq_bad, done_at;
    mode = 2;
    run_sweep(3'd1, 3'd1, seq_bad, done_at);
    tests++;
    if ({bus.max_err, bus.err_cnt, bus.fail_valid, bus.pass} !== {3'd1, 5'd16, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL inv_et1_results got me=%0d ec=%0d fv=%0d pass=%0d exp me=1 ec=16 fv=0 pass=1",
               bus.max_err, bus.err_cnt, bus.fail_valid, bus.pass);
    end
    run_sweep(3'd0, 3'd0, seq_bad, done_at);
    tests++;
    if ({bus.max_err, bus.err_cnt, bus.fail_valid, bus.fail_vec, bus.pass} !== {3'd1, 5'd16, 1'b1, 4'd0, 1'b0}) begin
      fails++;
      $display("FAIL inv_et0_results got me=%0d ec=%0d fv=%0d fvec=%0d pass=%0d exp me=1 ec=16 fv=1 fvec=0 pass=0",
               bus.max_err, bus.err_cnt, bus.fail_valid, bus.fail_vec, bus.pass);
    end
  endtask

  task automatic test_back_to_back();
    int seq_bad, dones;
    mode    = 0;
    seq_bad = 0;
    dones   = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.et    = 3'd0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (k <= 16 && (bus.dut_in !== 4'(k - 1) || bus.busy !== 1'b1)) seq_bad++;
      if (bus.done === 1'b1) dones++;
      bus.start = ((k % 3) == 0 || k >= 15) ? 1'b1 : 1'b0;
    end
    tests++;
    if (seq_bad !== 0 || dones !== 1 || bus.done !== 1'b1) begin
      fails++;
      $display("FAIL b2b_first_sweep got bad=%0d dones=%0d done=%0d exp bad=0 dones=1 done=1", seq_bad, dones, bus.done);
    end
    @(negedge clk);
    tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.dut_in !== 4'd0) begin
      fails++;
      $display("FAIL b2b_idle got busy=%0d done=%0d dut_in=%0d exp 0 0 0", bus.busy, bus.done, bus.dut_in);
    end
    @(negedge clk);
    bus.start = 1'b0;
    tests++;
    if (bus.busy !== 1'b1 || bus.dut_in !== 4'd0) begin
      fails++;
      $display("FAIL b2b_restart got busy=%0d dut_in=%0d exp busy=1 dut_in=0", bus.busy, bus.dut_in);
    end
    seq_bad = 0;
    dones   = 0;
    for (int k = 2; k <= 17; k++) begin
      @(negedge clk);
      if (k <= 16 && (bus.dut_in !== 4'(k - 1) || bus.busy !== 1'b1)) seq_bad++;
      if (bus.done === 1'b1) dones++;
    end
    tests++;
    if (seq_bad !== 0 || dones !== 1 || bus.done !== 1'b1 || bus.err_cnt !== 5'd0 || bus.pass !== 1'b1) begin
      fails++;
      $display("FAIL b2b_second_sweep got bad=%0d dones=%0d done=%0d ec=%0d pass=%0d exp 0 1 1 0 1",
               seq_bad, dones, bus.done, bus.err_cnt, bus.pass);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    int seq_bad, done_at;
    mode = 1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.et    = 3'd0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    tests++;
    if (bus.dut_in !== 4'd8 || bus.max_err === 3'd0) begin
      fails++;
      $display("FAIL midsweep_state got dut_in=%0d me=%0d exp dut_in=8 me>0", bus.dut_in, bus.max_err);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.dut_in, bus.busy, bus.done, bus.max_err, bus.err_cnt, bus.fail_valid, bus.fail_vec, bus.pass}
        !== {4'd0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0, 4'd0, 1'b1}) begin
      fails++;
      $display("FAIL async_reset got dut_in=%0d busy=%0d done=%0d me=%0d ec=%0d fv=%0d fvec=%0d pass=%0d exp 0 0 0 0 0 0 0 1",
               bus.dut_in, bus.busy, bus.done, bus.max_err, bus.err_cnt, bus.fail_valid, bus.fail_vec, bus.pass);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(3'd0, 3'd0, seq_bad, done_at);
    tests++;
    if (seq_bad !== 0 || done_at !== 17 ||
        {bus.max_err, bus.err_cnt, bus.fail_valid, bus.fail_vec, bus.pass} !== {3'd6, 5'd15, 1'b1, 4'd1, 1'b0}) begin
      fails++;
      $display("FAIL post_reset_sweep got bad=%0d done_at=%0d me=%0d ec=%0d fv=%0d fvec=%0d pass=%0d exp 0 17 6 15 1 1 0",
               seq_bad, done_at, bus.max_err, bus.err_cnt, bus.fail_valid, bus.fail_vec, bus.pass);
    end
  endtask

  task automatic test_et_change();
    int seq_bad, done_at;
    mode = 1;
    run_sweep(3'd0, 3'd7, seq_bad, done_at);
    tests++;
    if (seq_bad !== 0 || done_at !== 17 ||
        {bus.max_err, bus.err_cnt, bus.fail_valid, bus.fail_vec, bus.pass} !== {3'd6, 5'd15, 1'b1, 4'd1, 1'b0}) begin
      fails++;
      $display("FAIL et_change got bad=%0d done_at=%0d me=%0d ec=%0d fv=%0d fvec=%0d pass=%0d exp 0 17 6 15 1 1 0",
               seq_bad, done_at, bus.max_err, bus.err_cnt, bus.fail_valid, bus.fail_vec, bus.pass);
    end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_zero();
    test_inverted_lsb();
    test_back_to_back();
    test_async_reset();
    test_et_change();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
